// File: rtl/edge_frame_writer.sv
// edge_frame_writer
//   Collects edge-detector pixel beats, buffers them in a small FIFO and
//   writes them into a frame buffer through a valid/ready write port.
//   Beats are only accepted once a frame start (address 0) has been seen;
//   an overflow drops the beat, raises a sticky flag and resynchronises on
//   the next frame start. The non-zero pixels of each written frame are
//   counted and reported when the frame's last pixel is written.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   data_in      12-bit edge pixel
//   addr_in      19-bit pixel address
//   in_valid     input beat qualifier
//   mem_ready    frame-buffer port can accept a beat
//   mem_we       write request, high while the FIFO holds an entry
//   mem_addr     write address (FIFO head)
//   mem_data     write data (FIFO head)
//   frame_done   one-cycle pulse after the last pixel of a frame is written
//   edge_count   non-zero pixel count of the last completed frame
//   overflow     sticky input-drop flag
//   fifo_level   current FIFO occupancy
module edge_frame_writer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [11:0]                  data_in,
  input  logic [18:0]                  addr_in,
  input  logic                         in_valid,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [18:0]                  mem_addr,
  output logic [11:0]                  mem_data,
  output logic                         frame_done,
  output logic [18:0]                  edge_count,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [19:0]     PIXELS    = 20'(WIDTH * HEIGHT);
  localparam logic [18:0]     LAST_ADDR = 19'(WIDTH * HEIGHT - 1);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {SYNC, RUN} state_t;

  state_t             state_q;
  logic [30:0]        storage_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q;
  logic [PTR_W-1:0]   rdPtr_q;
  logic [PTR_W:0]     count_q;
  logic [PTR_W:0]     count_d;
  logic               memWe_q;
  logic               overflow_q;
  logic               frameDone_q;
  logic [18:0]        edgeCount_q;
  logic [18:0]        runCount_q;
  logic [18:0]        runCount_d;

  logic               pop;
  logic               full;
  logic               accept;
  logic               push;
  logic               drop;
  logic               lastPixel;

  // Fullness is taken from the registered count, so a pop in the same
  // cycle never makes room for a push that arrives while full.
  always_comb begin
    pop       = memWe_q & mem_ready;
    full      = (count_q == DEPTH_CNT);
    accept    = 1'b0;
    if (in_valid) begin
      if (state_q == SYNC) accept = (addr_in == 19'd0);
      else                 accept = ({1'b0, addr_in} < PIXELS);
    end
    push      = accept & ~full;
    drop      = accept & full;
    count_d   = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    lastPixel = pop & (mem_addr == LAST_ADDR);
    // Running count of non-zero pixels, held at its maximum once reached.
    runCount_d = runCount_q;
    if (pop && (mem_data != 12'd0) && (runCount_q != '1))
      runCount_d = runCount_q + 19'd1;
  end

  // Input state machine: waits for a frame start in SYNC, accepts in-frame
  // beats in RUN, and falls back to SYNC whenever a beat has to be dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      overflow_q <= 1'b0;
    end else if (drop) begin
      state_q    <= SYNC;
      overflow_q <= 1'b1;
    end else if (push) begin
      state_q    <= RUN;
    end
  end

  // FIFO storage and pointers; depth is a power of two so pointers wrap
  // naturally. mem_we is registered from the next occupancy so it is high
  // exactly while an entry is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) storage_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      memWe_q <= 1'b0;
    end else begin
      if (push) begin
        storage_q[wrPtr_q] <= {addr_in, data_in};
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      memWe_q <= (count_d != '0);
    end
  end

  // Frame statistics: on the write of the last pixel the total including
  // that pixel is published, the running count restarts and frame_done
  // pulses for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runCount_q  <= '0;
      edgeCount_q <= '0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= lastPixel;
      if (lastPixel) begin
        edgeCount_q <= runCount_d;
        runCount_q  <= '0;
      end else begin
        runCount_q  <= runCount_d;
      end
    end
  end

  assign mem_we     = memWe_q;
  assign mem_addr   = storage_q[rdPtr_q][30:12];
  assign mem_data   = storage_q[rdPtr_q][11:0];
  assign frame_done = frameDone_q;
  assign edge_count = edgeCount_q;
  assign overflow   = overflow_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer
//   Drives edge_frame_writer (8x8 frame, 8-entry FIFO) with directed and
//   randomized pixel traffic and compares it each cycle against a queue
//   based reference model of the frame writer.
module tb_edge_frame_writer;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int D      = 8;
  localparam int PIX    = W * H;
  localparam int MAXRUN = 524287;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in;
  logic [18:0] addr_in;
  logic        in_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_data;
  logic        frame_done;
  logic [18:0] edge_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  edge_frame_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .in_valid   (in_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .frame_done (frame_done),
    .edge_count (edge_count),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Reference model: a queue of pending {addr,data} beats, a sync flag and
  // the frame statistics, updated once per rising edge from the inputs.
  typedef struct {logic [18:0] a; logic [11:0] d;} beat_t;
  beat_t mq[$];
  bit    mSync;
  bit    mOvf;
  bit    mFd;
  int    mRun;
  int    mEdge;
  bit    mPop;
  bit    mFull;
  bit    mWant;
  beat_t mHead;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mSync = 1'b1;
      mOvf  = 1'b0;
      mFd   = 1'b0;
      mRun  = 0;
      mEdge = 0;
    end else begin
      mFull = (mq.size() == D);
      mPop  = (mq.size() > 0) && mem_ready;
      mWant = in_valid && (mSync ? (addr_in == 0) : (int'(addr_in) < PIX));
      mFd   = 1'b0;
      if (mPop) begin
        mHead = mq.pop_front();
        if (mHead.d != 0 && mRun < MAXRUN) mRun++;
        if (int'(mHead.a) == PIX - 1) begin
          mEdge = mRun;
          mRun  = 0;
          mFd   = 1'b1;
        end
      end
      if (mWant) begin
        if (mFull) begin
          mOvf  = 1'b1;
          mSync = 1'b1;
        end else begin
          mq.push_back('{addr_in, data_in});
          mSync = 1'b0;
        end
      end
    end
  end

  // Compare process on the falling edge, plus a record of DUT writes and
  // frame_done pulses used by the directed scenarios.
  logic [18:0] dutWritten[$];
  int          fdCount = 0;
  bit          prevStall = 1'b0;
  logic [18:0] prevAddr;
  logic [11:0] prevData;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_mem_we", int'(mem_we), 0);
      checkOutput("rst_mem_addr", int'(mem_addr), 0);
      checkOutput("rst_mem_data", int'(mem_data), 0);
      checkOutput("rst_frame_done", int'(frame_done), 0);
      checkOutput("rst_edge_count", int'(edge_count), 0);
      checkOutput("rst_overflow", int'(overflow), 0);
      checkOutput("rst_fifo_level", int'(fifo_level), 0);
      prevStall = 1'b0;
    end else begin
      checkOutput("mem_we", int'(mem_we), (mq.size() > 0) ? 1 : 0);
      checkOutput("fifo_level", int'(fifo_level), mq.size());
      checkOutput("overflow", int'(overflow), int'(mOvf));
      checkOutput("frame_done", int'(frame_done), int'(mFd));
      checkOutput("edge_count", int'(edge_count), mEdge);
      if (mq.size() > 0) begin
        checkOutput("mem_addr", int'(mem_addr), int'(mq[0].a));
        checkOutput("mem_data", int'(mem_data), int'(mq[0].d));
      end
      if (prevStall) begin
        checkOutput("stall_addr", int'(mem_addr), int'(prevAddr));
        checkOutput("stall_data", int'(mem_data), int'(prevData));
        checkOutput("stall_we", int'(mem_we), 1);
      end
      prevStall = mem_we && !mem_ready;
      prevAddr  = mem_addr;
      prevData  = mem_data;
      if (mem_we && mem_ready) dutWritten.push_back(mem_addr);
      if (frame_done) fdCount++;
    end
  end

  // One cycle of input, applied just after a rising edge.
  task automatic applyStimulus(input bit v, input int a, input int d, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    addr_in   = 19'(a);
    data_in   = 12'(d);
    mem_ready = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, r);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int randPixel();
    return ($urandom_range(1) == 0) ? 0 : int'($urandom_range(4095, 1));
  endfunction

  bit nz[PIX];
  int nzSet;
  int nzSent;
  bit inOrder;
  int seqAddr;
  int rr;
  int pix;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    addr_in   = '0;
    data_in   = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Full frame, one beat every 4th cycle, exactly 10 non-zero pixels.
    for (int i = 0; i < PIX; i++) nz[i] = 1'b0;
    nzSet = 0;
    while (nzSet < 10) begin
      rr = int'($urandom_range(PIX - 1));
      if (!nz[rr]) begin
        nz[rr] = 1'b1;
        nzSet++;
      end
    end
    dutWritten.delete();
    fdCount = 0;
    for (int a = 0; a < PIX; a++) begin
      applyStimulus(1'b1, a, nz[a] ? int'($urandom_range(4095, 1)) : 0, 1'b1);
      idle(3, 1'b1);
    end
    idle(6, 1'b1);
    @(negedge clk);
    checkOutput("frame_edge_count", int'(edge_count), 10);
    checkOutput("frame_done_pulses", fdCount, 1);
    checkOutput("frame_writes", dutWritten.size(), PIX);
    inOrder = 1'b1;
    foreach (dutWritten[i]) if (int'(dutWritten[i]) != i) inOrder = 1'b0;
    checkOutput("frame_order", int'(inOrder), 1);

    // Out-of-frame address while running is ignored.
    dutWritten.delete();
    applyStimulus(1'b1, PIX, 5, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    checkOutput("oor_writes", dutWritten.size(), 0);
    checkOutput("oor_overflow", int'(overflow), 0);
    checkOutput("oor_level", int'(fifo_level), 0);

    // After reset, beats before a frame start are discarded.
    doReset(3);
    dutWritten.delete();
    applyStimulus(1'b1, 5, 11, 1'b1);
    applyStimulus(1'b1, 6, 12, 1'b1);
    applyStimulus(1'b1, 7, 13, 1'b1);
    applyStimulus(1'b1, 0, 14, 1'b1);
    idle(4, 1'b1);
    @(negedge clk);
    checkOutput("sync_writes", dutWritten.size(), 1);
    if (dutWritten.size() > 0) checkOutput("sync_first_addr", int'(dutWritten[0]), 0);

    // Overflow: nine beats with the port stalled.
    doReset(2);
    for (int a = 0; a < 9; a++) applyStimulus(1'b1, a, a + 1, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    checkOutput("ovf_level", int'(fifo_level), 8);
    checkOutput("ovf_flag", int'(overflow), 1);
    dutWritten.delete();
    idle(12, 1'b1);
    @(negedge clk);
    checkOutput("ovf_drain_count", dutWritten.size(), 8);
    inOrder = 1'b1;
    foreach (dutWritten[i]) if (int'(dutWritten[i]) != i) inOrder = 1'b0;
    checkOutput("ovf_drain_order", int'(inOrder), 1);
    applyStimulus(1'b1, 9, 7, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    checkOutput("ovf_resync_level", int'(fifo_level), 0);
    checkOutput("ovf_resync_writes", dutWritten.size(), 8);

    // Ready toggling every cycle; stability is checked by the compare process.
    doReset(2);
    for (int a = 0; a < PIX; a++) begin
      applyStimulus(1'b1, a, randPixel(), 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 0, 0, i[0]);

    // Reset in the middle of a frame, then a clean frame.
    doReset(2);
    for (int a = 0; a < 20; a++) applyStimulus(1'b1, a, randPixel(), $urandom_range(1) == 1);
    doReset(2);
    nzSent = 0;
    for (int a = 0; a < PIX; a++) begin
      pix = randPixel();
      if (pix != 0) nzSent++;
      applyStimulus(1'b1, a, pix, 1'b1);
      idle(1, 1'b1);
    end
    idle(6, 1'b1);
    @(negedge clk);
    checkOutput("post_reset_edge_count", int'(edge_count), nzSent);

    // Random traffic: sequential frames with stray and out-of-frame beats,
    // random back-pressure and rare resets.
    seqAddr = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(999) < 2) begin
        doReset(2);
        seqAddr = 0;
      end
      rr = int'($urandom_range(99));
      if (rr < 55) begin
        applyStimulus(1'b1, seqAddr, randPixel(), $urandom_range(99) < 70);
        seqAddr = (seqAddr + 1) % PIX;
      end else if (rr < 60) begin
        applyStimulus(1'b1, PIX + int'($urandom_range(400)), randPixel(), $urandom_range(99) < 70);
      end else if (rr < 62) begin
        applyStimulus(1'b1, int'($urandom_range(PIX - 1)), randPixel(), $urandom_range(99) < 70);
      end else begin
        applyStimulus(1'b0, 0, 0, $urandom_range(99) < 70);
      end
    end
    idle(20, 1'b1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/edge_frame_writer.md
EDGE_FRAME_WRITER -- requirements
Module: edge_frame_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 640, frame width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 480, frame height in pixels.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, entry count, power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port data_in, input, 12 bits, edge pixel from the edge_detection data_out.
REQ-007 The block SHALL have port addr_in, input, 19 bits, pixel address from the edge_detection addr.
REQ-008 The block SHALL have port in_valid, input, 1 bit, beat qualifier from the edge_detection output_valid.
REQ-009 The block SHALL have port mem_ready, input, 1 bit, frame-buffer write port can accept a beat.
REQ-010 The block SHALL have port mem_we, output, 1 bit, write request (valid).
REQ-011 The block SHALL have port mem_addr, output, 19 bits, frame-buffer write address.
REQ-012 The block SHALL have port mem_data, output, 12 bits, frame-buffer write data.
REQ-013 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse at end of frame.
REQ-014 The block SHALL have port edge_count, output, 19 bits, non-zero pixel count of the last completed frame.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky input-drop flag.
REQ-016 The block SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-017 The block SHALL buffer {addr_in, data_in} beats in a FIFO of FIFO_DEPTH entries, draining them to the mem_* port.
REQ-018 The input FSM SHALL have two states: SYNC (the state after reset) and RUN.
REQ-019 In SYNC, the block SHALL discard beats with addr_in != 0; a beat with addr_in == 0 SHALL be pushed and SHALL move the FSM to RUN.
REQ-020 In RUN, every in_valid beat with addr_in < WIDTH*HEIGHT SHALL be pushed; beats with addr_in >= WIDTH*HEIGHT SHALL be discarded silently.
REQ-021 Fullness SHALL be evaluated before any same-cycle pop; a push attempted while full SHALL be dropped, even when a pop occurs in the same cycle.
REQ-022 A dropped push SHALL set overflow (sticky until reset) and SHALL move the FSM to SYNC.
REQ-023 FIFO contents already stored SHALL still drain after an overflow.
REQ-024 mem_we SHALL be registered and SHALL be high exactly while the FIFO holds at least one entry.
REQ-025 mem_addr and mem_data SHALL present the head entry.
REQ-026 A transfer SHALL occur on each rising edge where mem_we && mem_ready.
REQ-027 While mem_we is high and mem_ready is low, mem_we, mem_addr and mem_data SHALL hold stable.
REQ-028 Minimum latency SHALL be one cycle: a beat pushed at edge N into an empty FIFO appears with mem_we = 1 after edge N.
REQ-029 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_level unchanged.
REQ-030 With mem_ready held high, the block SHALL sustain one transfer per cycle.
REQ-031 A running counter SHALL increment on each transfer whose mem_data != 0.
REQ-032 On the transfer with mem_addr == WIDTH*HEIGHT-1, edge_count SHALL load the running total including that beat, and the running counter SHALL clear to 0.
REQ-033 frame_done SHALL pulse high for one cycle on the edge following the transfer in REQ-032.
REQ-034 The running counter SHALL saturate at 2^19-1.

Reset
REQ-035 While reset is high, the block SHALL force: mem_we = 0, mem_addr = 0, mem_data = 0, frame_done = 0, edge_count = 0, overflow = 0, fifo_level = 0, running counter = 0, FSM = SYNC.
REQ-036 Reset asserted mid-frame SHALL discard all FIFO contents; after release, the block SHALL ignore input until the next addr_in == 0 beat.

Verification (WIDTH=8, HEIGHT=8, FIFO_DEPTH=8)
REQ-037 Addresses 0..63 on every 4th cycle with mem_ready = 1 and 10 non-zero values -> 64 writes in address order, frame_done one cycle after the addr-63 transfer, edge_count = 10.
REQ-038 After reset, beats at addresses 5, 6, 7, then 0 -> the first mem_we carries mem_addr = 0, and addresses 5..7 are never written.
REQ-039 mem_ready = 0 while 9 consecutive beats (addresses 0..8) arrive -> fifo_level = 8, overflow = 1, addresses 0..7 drain when mem_ready rises, FSM in SYNC.
REQ-040 mem_ready toggling 1/0 every cycle -> mem_addr and mem_data never change while mem_we = 1 and mem_ready = 0.
REQ-041 Reset pulsed after 20 beats -> all outputs at reset values during reset; the next frame from address 0 gives the correct edge_count.
REQ-042 A beat with addr_in = 64 in RUN -> no write, no overflow, fifo_level unchanged.
